// File: rtl/plb_dac_stream.sv
// plb_dac_stream: PLB slave that streams FIFO-buffered samples to a multi-channel DAC
// at a programmable rate, with a HOLD sample used whenever the FIFO runs dry.
// Build option: define PLB_DAC_OFFSET_BINARY_EN to invert each channel MSB on the DAC
// output (two's-complement samples become offset binary); the default build passes
// samples through unmodified.
module plb_dac_stream #(
  parameter int unsigned C_DAC_WIDTH  = 10,
  parameter int unsigned C_NUM_CH     = 2,
  parameter int unsigned C_FIFO_DEPTH = 16
) (
  input  logic                            Bus2IP_Clk,
  input  logic                            Bus2IP_Resetn,
  input  logic [0:31]                     Bus2IP_Data,
  input  logic [0:3]                      Bus2IP_RdCE,
  input  logic [0:3]                      Bus2IP_WrCE,
  output logic [0:31]                     IP2Bus_Data,
  output logic                            IP2Bus_RdAck,
  output logic                            IP2Bus_WrAck,
  output logic                            IP2Bus_Error,
  output logic [C_NUM_CH*C_DAC_WIDTH-1:0] IP2DAC_Data,
  output logic                            IP2DAC_DCLK,
  output logic                            IP2DAC_Update
);

  localparam int unsigned DW       = C_NUM_CH * C_DAC_WIDTH;
  localparam int unsigned AW       = $clog2(C_FIFO_DEPTH);
  localparam int unsigned LW       = AW + 1;
  localparam int unsigned DIVW     = 16;
  localparam int unsigned REG_CTRL = 0;
  localparam int unsigned REG_DATA = 1;
  localparam int unsigned REG_STAT = 2;
  localparam int unsigned REG_HOLD = 3;

  // One bit set at the MSB of every channel field.
  function automatic logic [DW-1:0] msb_mask();
    logic [DW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < C_NUM_CH; i++) begin
      m[i*C_DAC_WIDTH + C_DAC_WIDTH - 1] = 1'b1;
    end
    return m;
  endfunction

`ifdef PLB_DAC_OFFSET_BINARY_EN
  localparam logic [DW-1:0] OUT_XOR = msb_mask();
`else
  localparam logic [DW-1:0] OUT_XOR = '0;
`endif

  // Bus-side views in conventional (LSB = 0) numbering.
  logic [31:0] wdata;
  logic [3:0]  wr_ce;
  logic [3:0]  rd_ce;

  assign wdata = Bus2IP_Data;
  assign wr_ce = {Bus2IP_WrCE[3], Bus2IP_WrCE[2], Bus2IP_WrCE[1], Bus2IP_WrCE[0]};
  assign rd_ce = {Bus2IP_RdCE[3], Bus2IP_RdCE[2], Bus2IP_RdCE[1], Bus2IP_RdCE[0]};

  // State
  logic [3:0]      wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;
  logic [DIVW-1:0] div_q, div_d, div_act_q, div_act_d, cnt_q, cnt_d;
  logic            en_q, en_d;
  logic [DW-1:0]   hold_q, hold_d, dac_q, dac_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            dclk_q, dclk_d, upd_q, upd_d;
  logic            wrack_q, wrack_d, rdack_q, rdack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [DW-1:0]   mem_q [C_FIFO_DEPTH];

  // Decode
  logic [3:0]      wr_stb, rd_stb;
  logic            fifo_empty, fifo_full, flush, push_req, push, pop, tick;
  logic [DW-1:0]   pop_word;
  logic [DIVW-1:0] div_eff;

  // Access strobes on CE rising edges, FIFO push/pop arbitration and divider tick.
  always_comb begin
    wr_stb     = wr_ce & ~wr_prev_q;
    rd_stb     = rd_ce & ~rd_prev_q;
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LW'(C_FIFO_DEPTH));
    flush      = wr_stb[REG_CTRL] & wdata[1];
    push_req   = wr_stb[REG_DATA] & ~flush;
    tick       = en_q & (cnt_q == div_act_q);
    pop        = tick & ~flush & (~fifo_empty | push_req);
    push       = push_req & (~fifo_full | pop);
    pop_word   = fifo_empty ? wdata[DW-1:0] : mem_q[rd_ptr_q];
  end

  // Control, HOLD and sticky status registers.
  always_comb begin
    div_d  = div_q;
    en_d   = en_q;
    hold_d = hold_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (wr_stb[REG_CTRL]) begin
      div_d = wdata[31:16];
      en_d  = wdata[0];
    end
    if (wr_stb[REG_HOLD]) begin
      hold_d = wdata[DW-1:0];
    end
    if (wr_stb[REG_STAT] && wdata[3]) ovf_d = 1'b0;
    if (wr_stb[REG_STAT] && wdata[2]) unf_d = 1'b0;
    // Set events win over a same-cycle clear.
    if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    if (tick && !flush && !pop)        unf_d = 1'b1;
  end

  // Rate divider: period latched at each wrap (or while idle), DCLK high in the second half.
  always_comb begin
    div_eff   = (div_d == '0) ? DIVW'(1) : div_d;
    div_act_d = div_act_q;
    cnt_d     = cnt_q + DIVW'(1);
    if (!en_q || tick) begin
      div_act_d = div_eff;
    end
    if (!en_q || !en_d || tick) begin
      cnt_d = '0;
    end
    dclk_d = (cnt_d > (div_act_d >> 1));
  end

  // FIFO pointers and level; flush empties everything in one cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop) level_d = level_q + LW'(1);
      if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  // DAC output: on each tick load the popped word, or HOLD when nothing is available.
  always_comb begin
    dac_d = dac_q;
    upd_d = 1'b0;
    if (tick && !flush) begin
      upd_d = 1'b1;
      dac_d = (pop ? pop_word : hold_q) ^ OUT_XOR;
    end
  end

  // Bus acks and registered read data.
  always_comb begin
    wr_prev_d = wr_ce;
    rd_prev_d = rd_ce;
    wrack_d   = |wr_stb;
    rdack_d   = |rd_stb;
    rdata_d   = '0;
    if (rd_stb[REG_CTRL]) begin
      rdata_d = {div_q, 15'b0, en_q};
    end else if (rd_stb[REG_STAT]) begin
      rdata_d = {16'b0, 8'(level_q), 4'b0, ovf_q, unf_q, fifo_full, fifo_empty};
    end else if (rd_stb[REG_HOLD]) begin
      rdata_d = 32'(hold_q);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) begin
      wr_prev_q <= '0;
      rd_prev_q <= '0;
      div_q     <= '0;
      en_q      <= 1'b0;
      hold_q    <= '0;
      div_act_q <= DIVW'(1);
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      dac_q     <= '0;
      dclk_q    <= 1'b0;
      upd_q     <= 1'b0;
      wrack_q   <= 1'b0;
      rdack_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wr_prev_q <= wr_prev_d;
      rd_prev_q <= rd_prev_d;
      div_q     <= div_d;
      en_q      <= en_d;
      hold_q    <= hold_d;
      div_act_q <= div_act_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      dac_q     <= dac_d;
      dclk_q    <= dclk_d;
      upd_q     <= upd_d;
      wrack_q   <= wrack_d;
      rdack_q   <= rdack_d;
      rdata_q   <= rdata_d;
    end
  end

  // Sample storage; contents need no reset since the pointers define validity.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Resetn && push) begin
      mem_q[wr_ptr_q] <= wdata[DW-1:0];
    end
  end

  assign IP2Bus_Data   = rdata_q;
  assign IP2Bus_RdAck  = rdack_q;
  assign IP2Bus_WrAck  = wrack_q;
  assign IP2Bus_Error  = 1'b0;
  assign IP2DAC_Data   = dac_q;
  assign IP2DAC_DCLK   = dclk_q;
  assign IP2DAC_Update = upd_q;

endmodule

// File: tb/tb_plb_dac_stream.sv
// tb_plb_dac_stream: self-checking bench for plb_dac_stream with a queue-based sample model.
module tb_plb_dac_stream;

  localparam int W     = 10;
  localparam int NCH   = 2;
  localparam int DW    = W * NCH;
  localparam int R_CTRL = 0;
  localparam int R_DATA = 1;
  localparam int R_STAT = 2;
  localparam int R_HOLD = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [0:31]   bdata = '0;
  logic [0:3]    rdce = '0;
  logic [0:3]    wrce = '0;
  logic [0:31]   ip_data;
  logic          rdack, wrack, err;
  logic [DW-1:0] dac;
  logic          dclk, upd;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  logic [31:0] q[$];

  plb_dac_stream #(.C_DAC_WIDTH(W), .C_NUM_CH(NCH), .C_FIFO_DEPTH(16)) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rstn), .Bus2IP_Data(bdata),
    .Bus2IP_RdCE(rdce), .Bus2IP_WrCE(wrce), .IP2Bus_Data(ip_data),
    .IP2Bus_RdAck(rdack), .IP2Bus_WrAck(wrack), .IP2Bus_Error(err),
    .IP2DAC_Data(dac), .IP2DAC_DCLK(dclk), .IP2DAC_Update(upd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected DAC word for a bus-side sample.
  function automatic logic [DW-1:0] to_dac(input logic [31:0] w);
    logic [DW-1:0] v;
    v = w[DW-1:0];
`ifdef PLB_DAC_OFFSET_BINARY_EN
    for (int c = 0; c < NCH; c++) v[c*W + W - 1] = ~v[c*W + W - 1];
`endif
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; wrce = '0; rdce = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic bus_wr(input int idx, input logic [31:0] d, output logic ack);
    @(negedge clk);
    bdata = d; wrce[idx] = 1'b1;
    @(negedge clk);
    ack = wrack; wrce[idx] = 1'b0;
  endtask

  task automatic bus_rd(input int idx, output logic [31:0] d, output logic ack);
    @(negedge clk);
    rdce[idx] = 1'b1;
    @(negedge clk);
    d = ip_data; ack = rdack; rdce[idx] = 1'b0;
  endtask

  task automatic wait_upd(input int limit, output int stamp, output logic seen);
    int n;
    seen = 1'b0; n = 0; stamp = 0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      if (upd === 1'b1) begin seen = 1'b1; stamp = cyc_cnt; end
    end
  endtask

  // Disable, flush and clear sticky flags.
  task automatic idle_fifo();
    logic a;
    bus_wr(R_CTRL, 32'h0000_0002, a);
    bus_wr(R_STAT, 32'h0000_000C, a);
    q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic a;
    do_reset();
    n_tests++; if ({dac, dclk, upd} !== '0) begin n_fail++; $display("FAIL reset_dac: got dac=%h dclk=%b upd=%b, want 0", dac, dclk, upd); end
    n_tests++; if ({ip_data, rdack, wrack, err} !== '0) begin n_fail++; $display("FAIL reset_bus: got data=%h rdack=%b wrack=%b err=%b, want 0", ip_data, rdack, wrack, err); end
    bus_rd(R_STAT, d, a);
    n_tests++; if (d !== 32'h1 || a !== 1'b1) begin n_fail++; $display("FAIL reset_status: got %h ack=%b, want 00000001 ack=1", d, a); end
    bus_rd(R_CTRL, d, a);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h, want 0", d); end
    // Reset during an access aborts it without ack.
    @(negedge clk);
    bdata = 32'h0003_5A5A; wrce[R_HOLD] = 1'b1; rstn = 1'b0;
    @(negedge clk);
    a = wrack; wrce[R_HOLD] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    n_tests++; if (a !== 1'b0) begin n_fail++; $display("FAIL reset_abort_ack: got %b, want 0", a); end
    bus_rd(R_HOLD, d, a);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_abort_hold: got %h, want 0", d); end
  endtask

  task automatic test_readback();
    logic [31:0] d, r; logic a;
    logic [15:0] dv;
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      bus_wr(R_HOLD, r, a);
      n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL hold_wrack: got %b, want 1", a); end
      bus_rd(R_HOLD, d, a);
      n_tests++; if (d !== (r & 32'h000F_FFFF)) begin n_fail++; $display("FAIL hold_read: got %h, want %h", d, r & 32'h000F_FFFF); end
      dv = 16'($urandom);
      r = {dv, 14'($urandom), 1'b1, 1'b0};
      bus_wr(R_CTRL, r, a);
      bus_rd(R_CTRL, d, a);
      n_tests++; if (d !== {dv, 16'h0000}) begin n_fail++; $display("FAIL ctrl_read: got %h, want %h", d, {dv, 16'h0000}); end
    end
    bus_rd(R_DATA, d, a);
    n_tests++; if (d !== 32'h0 || a !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL data_read: got %h ack=%b err=%b, want 0 ack=1 err=0", d, a, err); end
    bus_wr(R_CTRL, 32'h0, a);
  endtask

  task automatic test_basic_stream();
    logic [31:0] d; logic a, seen; int st0, st1;
    do_reset();
    bus_wr(R_CTRL, 32'h0004_0001, a);
    bus_wr(R_DATA, 32'h0000_1234, a);
    wait_upd(20, st0, seen);
    n_tests++; if (!seen || dac !== to_dac(32'h1234)) begin n_fail++; $display("FAIL basic_first: seen=%b got %h, want %h", seen, dac, to_dac(32'h1234)); end
    wait_upd(20, st1, seen);
    n_tests++; if (!seen || (st1 - st0) != 5 || dac !== to_dac(32'h0)) begin n_fail++; $display("FAIL basic_hold: seen=%b period=%0d data=%h, want period 5 data %h", seen, st1 - st0, dac, to_dac(32'h0)); end
    bus_rd(R_STAT, d, a);
    n_tests++; if (d !== 32'h5) begin n_fail++; $display("FAIL basic_unf: got %h, want 00000005", d); end
    bus_wr(R_CTRL, 32'h0, a);
  endtask

  task automatic test_stream_random();
    logic [31:0] d, w, hold; logic a, seen; logic [15:0] dv;
    int p, n, st, prev;
    logic [DW-1:0] exp;
    for (int it = 0; it < 6; it++) begin
      dv = 16'($urandom_range(0, 6));
      p = (dv == 0) ? 2 : int'(dv) + 1;
      n = $urandom_range(1, 8);
      hold = $urandom;
      idle_fifo();
      bus_wr(R_HOLD, hold, a);
      for (int i = 0; i < n; i++) begin
        w = $urandom; bus_wr(R_DATA, w, a); q.push_back(w);
      end
      bus_wr(R_CTRL, {dv, 16'h0001}, a);
      prev = 0;
      for (int k = 0; k <= n; k++) begin
        wait_upd(3 * p + 4, st, seen);
        exp = (q.size() > 0) ? to_dac(q.pop_front()) : to_dac(hold);
        n_tests++;
        if (!seen || dac !== exp || (k > 0 && (st - prev) != p)) begin
          n_fail++;
          $display("FAIL stream_rand it=%0d k=%0d: seen=%b data=%h period=%0d, want data=%h period=%0d", it, k, seen, dac, st - prev, exp, p);
        end
        prev = st;
      end
      bus_wr(R_CTRL, 32'h0, a);
      bus_rd(R_STAT, d, a);
      n_tests++; if (d !== 32'h5) begin n_fail++; $display("FAIL stream_status it=%0d: got %h, want 00000005", it, d); end
    end
  endtask

  task automatic test_div_change();
    logic a, seen; int st0, st1, st2;
    idle_fifo();
    bus_wr(R_CTRL, 32'h0003_0001, a);
    wait_upd(20, st0, seen);
    bus_wr(R_CTRL, 32'h0007_0001, a);
    wait_upd(20, st1, seen);
    wait_upd(30, st2, seen);
    n_tests++; if ((st1 - st0) != 4 || (st2 - st1) != 8) begin n_fail++; $display("FAIL div_change: periods %0d,%0d, want 4,8", st1 - st0, st2 - st1); end
    bus_wr(R_CTRL, 32'h0, a);
  endtask

  task automatic test_en_clear();
    logic a, seen; logic [31:0] w, h2; int st, st0, ups;
    idle_fifo();
    w = $urandom; h2 = $urandom;
    bus_wr(R_DATA, w, a);
    bus_wr(R_CTRL, 32'h0009_0001, a);
    wait_upd(20, st, seen);
    n_tests++; if (!seen || dac !== to_dac(w)) begin n_fail++; $display("FAIL en_first: seen=%b got %h, want %h", seen, dac, to_dac(w)); end
    bus_wr(R_CTRL, 32'h0009_0000, a);
    ups = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (upd === 1'b1 || dclk === 1'b1) ups++;
    end
    n_tests++; if (ups != 0 || dac !== to_dac(w)) begin n_fail++; $display("FAIL en_off: activity=%0d data=%h, want 0 and %h", ups, dac, to_dac(w)); end
    bus_wr(R_HOLD, h2, a);
    bus_wr(R_CTRL, 32'h0009_0001, a);
    st0 = cyc_cnt;
    wait_upd(40, st, seen);
    n_tests++; if (!seen || (st - st0) != 10 || dac !== to_dac(h2)) begin n_fail++; $display("FAIL en_restart: seen=%b delay=%0d data=%h, want 10 and %h", seen, st - st0, dac, to_dac(h2)); end
    bus_wr(R_CTRL, 32'h0, a);
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic a;
    idle_fifo();
    for (int i = 0; i < 17; i++) bus_wr(R_DATA, $urandom, a);
    bus_rd(R_STAT, d, a);
    n_tests++; if (d !== 32'h0000_100A) begin n_fail++; $display("FAIL ovf_set: got %h, want 0000100a", d); end
    bus_wr(R_STAT, 32'h0000_0008, a);
    bus_rd(R_STAT, d, a);
    n_tests++; if (d !== 32'h0000_1002) begin n_fail++; $display("FAIL ovf_clear: got %h, want 00001002", d); end
    // Dropped push and OVF clear in the same cycle: flag stays set.
    @(negedge clk);
    bdata = 32'h0000_0008; wrce[R_DATA] = 1'b1; wrce[R_STAT] = 1'b1;
    @(negedge clk);
    wrce = '0;
    bus_rd(R_STAT, d, a);
    n_tests++; if (d !== 32'h0000_100A) begin n_fail++; $display("FAIL ovf_set_wins: got %h, want 0000100a", d); end
  endtask

  task automatic test_full_tick();
    logic [31:0] d, w; logic a, seen; int st, prev;
    logic [DW-1:0] exp;
    idle_fifo();
    for (int i = 0; i < 16; i++) begin w = $urandom; bus_wr(R_DATA, w, a); q.push_back(w); end
    bus_wr(R_CTRL, 32'h0007_0001, a);
    wait_upd(30, st, seen);
    exp = to_dac(q.pop_front());
    n_tests++; if (!seen || dac !== exp) begin n_fail++; $display("FAIL full_first: seen=%b got %h, want %h", seen, dac, exp); end
    w = $urandom; bdata = w; wrce[R_DATA] = 1'b1; q.push_back(w);
    @(negedge clk);
    wrce[R_DATA] = 1'b0;
    repeat (6) @(negedge clk);
    w = $urandom; bdata = w; wrce[R_DATA] = 1'b1;
    @(negedge clk);
    wrce[R_DATA] = 1'b0;
    exp = to_dac(q.pop_front()); q.push_back(w);
    n_tests++; if (upd !== 1'b1 || dac !== exp) begin n_fail++; $display("FAIL full_coincide: upd=%b got %h, want upd=1 %h", upd, dac, exp); end
    bus_wr(R_CTRL, 32'h0007_0000, a);
    bus_rd(R_STAT, d, a);
    n_tests++; if (d !== 32'h0000_1002) begin n_fail++; $display("FAIL full_status: got %h, want 00001002", d); end
    bus_wr(R_CTRL, 32'h0000_0001, a);
    prev = 0;
    for (int k = 0; k < 16; k++) begin
      wait_upd(10, st, seen);
      exp = to_dac(q.pop_front());
      n_tests++;
      if (!seen || dac !== exp || (k > 0 && (st - prev) != 2)) begin
        n_fail++;
        $display("FAIL full_drain k=%0d: seen=%b data=%h period=%0d, want %h period 2", k, seen, dac, st - prev, exp);
      end
      prev = st;
    end
    bus_wr(R_CTRL, 32'h0, a);
  endtask

  task automatic test_flush();
    logic [31:0] d; logic a, seen; int st;
    logic [DW-1:0] d0;
    idle_fifo();
    bus_wr(R_HOLD, 32'h0, a);
    for (int i = 0; i < 5; i++) bus_wr(R_DATA, $urandom, a);
    d0 = dac;
    @(negedge clk);
    bdata = 32'h0000_0002; wrce[R_CTRL] = 1'b1; wrce[R_DATA] = 1'b1;
    @(negedge clk);
    wrce = '0;
    bus_rd(R_STAT, d, a);
    n_tests++; if (d !== 32'h1 || dac !== d0) begin n_fail++; $display("FAIL flush: status=%h data=%h, want 00000001 data %h", d, dac, d0); end
    bus_wr(R_CTRL, 32'h0001_0001, a);
    wait_upd(10, st, seen);
    n_tests++; if (!seen || dac !== to_dac(32'h0)) begin n_fail++; $display("FAIL flush_hold: seen=%b got %h, want %h", seen, dac, to_dac(32'h0)); end
    bus_wr(R_CTRL, 32'h0, a);
    bus_rd(R_STAT, d, a);
    n_tests++; if (d !== 32'h5) begin n_fail++; $display("FAIL flush_unf: got %h, want 00000005", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic a; int acks;
    idle_fifo();
    @(negedge clk);
    bdata = $urandom; wrce[R_DATA] = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (wrack === 1'b1) acks++; end
    wrce = '0;
    @(negedge clk); if (wrack === 1'b1) acks++;
    n_tests++; if (acks != 1) begin n_fail++; $display("FAIL ce_hold_wrack: got %0d pulses, want 1", acks); end
    bus_rd(R_STAT, d, a);
    n_tests++; if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL ce_hold_level: got %h, want 00000100", d); end
    @(negedge clk);
    rdce[R_STAT] = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (rdack === 1'b1) acks++; end
    rdce = '0;
    @(negedge clk); if (rdack === 1'b1) acks++;
    n_tests++; if (acks != 1) begin n_fail++; $display("FAIL ce_hold_rdack: got %0d pulses, want 1", acks); end
  endtask

  task automatic test_dclk();
    logic a, seen; logic [31:0] w0, w1; int st, lo, hi; logic stable;
    idle_fifo();
    w0 = $urandom; w1 = ~w0;
    bus_wr(R_DATA, w0, a);
    bus_wr(R_DATA, w1, a);
    bus_wr(R_CTRL, 32'h01F4_0001, a);
    wait_upd(600, st, seen);
    n_tests++; if (!seen || dac !== to_dac(w0) || dclk !== 1'b0) begin n_fail++; $display("FAIL dclk_first: seen=%b data=%h dclk=%b, want %h dclk=0", seen, dac, dclk, to_dac(w0)); end
    lo = 0; hi = 0; stable = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      if (dclk === 1'b0 && hi == 0) lo++;
      else if (dclk === 1'b1) hi++;
      else break;
      if (dac !== to_dac(w0)) stable = 1'b0;
      @(negedge clk);
    end
    n_tests++; if (lo != 251 || hi != 250 || !stable) begin n_fail++; $display("FAIL dclk_duty: low=%0d high=%0d stable=%b, want 251 250 1", lo, hi, stable); end
    n_tests++; if (upd !== 1'b1 || dac !== to_dac(w1)) begin n_fail++; $display("FAIL dclk_fall_update: upd=%b data=%h, want 1 %h", upd, dac, to_dac(w1)); end
    bus_wr(R_CTRL, 32'h0, a);
  endtask

  initial begin
    test_reset();
    test_readback();
    test_basic_stream();
    test_stream_random();
    test_div_change();
    test_en_clear();
    test_overflow();
    test_full_tick();
    test_flush();
    test_back_to_back();
    test_dclk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plb_dac_stream.md
PLB_DAC_STREAM -- requirements
Module: plb_dac_stream

Interface
REQ-001 Parameter C_DAC_WIDTH, default 10: bits per DAC channel sample.
REQ-002 Parameter C_NUM_CH, default 2: number of DAC channels; C_NUM_CH*C_DAC_WIDTH SHALL be <= 32.
REQ-003 Parameter C_FIFO_DEPTH, default 16: sample FIFO depth in words; it SHALL be a power of 2 and >= 4.
REQ-004 Bus2IP_Clk  in  1  single clock; all logic on the rising edge.
REQ-005 Bus2IP_Resetn  in  1  reset, synchronous, active-low.
REQ-006 Bus2IP_Data  in  [0:31]  write data; bit 31 is the LSB.
REQ-007 Bus2IP_RdCE / Bus2IP_WrCE  in  [0:3]  register selects; bit 0 = CTRL, bit 1 = DATA, bit 2 = STATUS, bit 3 = HOLD.
REQ-008 IP2Bus_Data  out  [0:31]  read data; IP2Bus_RdAck / IP2Bus_WrAck / IP2Bus_Error  out  1 each.
REQ-009 IP2DAC_Data  out  C_NUM_CH*C_DAC_WIDTH  packed samples; channel 0 occupies the LSBs.
REQ-010 IP2DAC_DCLK  out  1  DAC latch clock; IP2DAC_Update  out  1  one-cycle strobe on each sample change.

Function
REQ-011 Bus accesses: an access SHALL be taken on the 0->1 edge of any CE bit; a CE held high SHALL produce exactly one access.
REQ-012 The matching ack SHALL pulse for one cycle, one cycle after the CE edge. IP2Bus_Error SHALL be 0 always.
REQ-013 CTRL register: bits [0:15] = DIV, bit 30 = FLUSH (self-clearing), bit 31 = EN. Reads return DIV and EN; the FLUSH bit reads 0.
REQ-014 DATA register write: pushes the low C_NUM_CH*C_DAC_WIDTH bits into the FIFO.
REQ-015 DATA write when the FIFO is full: the sample is dropped and sticky OVF is set.
REQ-016 DATA reads SHALL return 0.
REQ-017 STATUS register (read): [16:23] = FIFO level, bit 28 = OVF, bit 29 = UNF, bit 30 = FULL, bit 31 = EMPTY.
REQ-018 STATUS register write: writing 1 to bit 28 or bit 29 clears that sticky flag; a clear in the same cycle as a set event leaves the flag set.
REQ-019 HOLD register (read/write): holds the sample driven when the FIFO is empty at a tick.
REQ-020 Period: P = DIV+1 cycles; DIV=0 SHALL be treated as DIV=1.
REQ-021 Divider counter: counts 0..DIV while EN=1 and is held at 0 while EN=0. A tick occurs when the count equals DIV.
REQ-022 On a tick with the FIFO not empty: pop one word into IP2DAC_Data on the next edge and pulse IP2DAC_Update.
REQ-023 On a tick with the FIFO empty: load HOLD into IP2DAC_Data, set UNF, and pulse IP2DAC_Update.
REQ-024 IP2DAC_DCLK SHALL be 1 while count > (DIV>>1), else 0. The data therefore changes on the DCLK falling edge and is stable at the rising edge.
REQ-025 A push and a pop in the same cycle SHALL leave the level unchanged; this also applies when the FIFO is full or empty at the start of that cycle (no OVF, no UNF).
REQ-026 FIFO pointers SHALL wrap modulo C_FIFO_DEPTH. The level SHALL be held in log2(C_FIFO_DEPTH)+1 bits, zero-extended into STATUS.
REQ-027 FLUSH SHALL empty the FIFO in one cycle. A concurrent push SHALL be discarded, and IP2DAC_Data SHALL be unchanged.
REQ-028 Clearing EN mid-period SHALL zero the counter on the next edge and keep IP2DAC_Data. A DIV write SHALL take effect at the next wrap or while EN=0.

Reset
REQ-029 On Bus2IP_Resetn=0 at an edge, the following SHALL be set to 0: CTRL, HOLD, FIFO pointers, level, OVF, UNF, counter, IP2DAC_Data, IP2DAC_DCLK, IP2DAC_Update, all acks and IP2Bus_Data; CE edge detectors SHALL be cleared.
REQ-030 Reset mid-period or mid-access SHALL abort it; no ack SHALL be issued for an access in flight.

Configuration
REQ-031 Macro PLB_DAC_OFFSET_BINARY_EN defined: each channel's MSB SHALL be inverted between the FIFO/HOLD path and IP2DAC_Data, so two's-complement input becomes offset binary. HOLD and DATA readback are unaffected.
REQ-032 Macro PLB_DAC_OFFSET_BINARY_EN undefined: samples pass unmodified.

Verification
REQ-033 Reset, write CTRL=0x0004_0001 (DIV=4, EN=1), push 0x0000_1234 -> IP2DAC_Update every 5 cycles; first sample 0x234 (ch0) and 0x004 (ch1); UNF set on the next tick with data = HOLD = 0.
REQ-034 Push 17 words with EN=0 and depth 16 -> STATUS level=16, FULL=1, OVF=1; write STATUS 0x0000_0008 -> OVF=0.
REQ-035 CTRL=0x01F4_0001 (DIV=500) -> DCLK low for 251 cycles, then high for 250; IP2DAC_Data changes only at the DCLK falling edge.
REQ-036 FIFO full, push coincides with a tick -> level stays 16, OVF stays 0, popped word is the oldest.
REQ-037 Write CTRL FLUSH with 5 words queued -> level=0 and EMPTY=1 on the next read. With PLB_DAC_OFFSET_BINARY_EN and HOLD=0x000 -> IP2DAC_Data=0x80200.
REQ-038 Hold WrCE bit 1 high for 10 cycles -> exactly one push and one WrAck pulse.
